// File: rtl/sa_ram_rsp_pkg.sv
// Shared constants and types for the RAM responder: requester ids and LFSR helpers.
package sa_ram_rsp_pkg;

    localparam int NUM_REQ = 4;
    localparam int NUM_RD  = NUM_REQ - 1;

    typedef enum logic [1:0] {
        REQ_MM2S_0,
        REQ_MM2S_1,
        REQ_MM2S_2,
        REQ_S2MM
    } req_id_t;

    localparam logic [7:0] LFSR_SEED = 8'hA5;

    // Fibonacci LFSR, taps 8,6,5,4 (bits 7,5,4,3), shifting toward the MSB.
    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

endpackage

// File: rtl/sa_ram_responder_rr_arbiter.sv
// Round-robin arbiter: one-hot grant starting at the pointer; the pointer is its only state.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req_i,
    input  logic                 stall_i,
    output logic [N-1:0]         grant_o,
    output logic [$clog2(N)-1:0] ptr_o
);

    localparam int PW = $clog2(N);

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic [PW-1:0] cand;
    logic [PW-1:0] win_idx;
    logic          win_vld;

    // NOTE: non-blocking assignment for registered state so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // NOTE: every variable gets a default before the loop, so no path leaves it unassigned (no latch).
    always_comb begin
        win_vld = 1'b0;
        win_idx = ptr_q;
        cand    = ptr_q;
        for (int i = 0; i < N; i++) begin
            cand = PW'((int'(ptr_q) + i) % N);
            if (!win_vld && req_i[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
    end

    // A stalled cycle grants nothing and leaves the pointer where it was.
    always_comb begin
        ptr_d = ptr_q;
        if (win_vld && !stall_i) begin
            ptr_d = PW'((int'(win_idx) + 1) % N);
        end
    end

    always_comb begin
        grant_o = '0;
        if (win_vld && !stall_i) begin
            grant_o[win_idx] = 1'b1;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/sa_ram_responder.sv
// Single-port word RAM serving three read ports and one write port, one access per cycle.
// Define SA_RAM_RSP_STALL_EN to add LFSR-driven stall cycles for back-pressure testing.
module sa_ram_responder
    import sa_ram_rsp_pkg::*;
#(
    parameter int AXI_WIDTH      = 128,
    parameter int ADDR_WIDTH     = 32,
    parameter int AXI_STRB_WIDTH = AXI_WIDTH / 8,
    parameter int DEPTH          = 4096,
    parameter int STALL_THRESH   = 192,
    parameter int LSB            = $clog2(AXI_WIDTH) - 3
) (
    input  logic                      clk,
    input  logic                      rst,

    input  logic                      mm2s_0_rd_en,
    input  logic [ADDR_WIDTH-1:0]     mm2s_0_rd_addr,
    output logic [AXI_WIDTH-1:0]      mm2s_0_rd_data,
    output logic                      mm2s_0_rd_wait,
    output logic                      mm2s_0_rd_ack,

    input  logic                      mm2s_1_rd_en,
    input  logic [ADDR_WIDTH-1:0]     mm2s_1_rd_addr,
    output logic [AXI_WIDTH-1:0]      mm2s_1_rd_data,
    output logic                      mm2s_1_rd_wait,
    output logic                      mm2s_1_rd_ack,

    input  logic                      mm2s_2_rd_en,
    input  logic [ADDR_WIDTH-1:0]     mm2s_2_rd_addr,
    output logic [AXI_WIDTH-1:0]      mm2s_2_rd_data,
    output logic                      mm2s_2_rd_wait,
    output logic                      mm2s_2_rd_ack,

    input  logic                      s2mm_wr_en,
    input  logic [ADDR_WIDTH-1:0]     s2mm_wr_addr,
    input  logic [AXI_WIDTH-1:0]      s2mm_wr_data,
    input  logic [AXI_STRB_WIDTH-1:0] s2mm_wr_strb,
    output logic                      s2mm_wr_wait,
    output logic                      s2mm_wr_ack
);

    localparam int AW = $clog2(DEPTH);

    logic [NUM_REQ-1:0]         req;
    logic [NUM_REQ-1:0]         grant;
    logic [$clog2(NUM_REQ)-1:0] arb_ptr;
    logic                       stall;

    logic [ADDR_WIDTH-1:0]      rd_addr [NUM_RD];
    logic [AW-1:0]              acc_word;
    logic                       rd_any;
    logic                       mem_we;

    logic [AXI_WIDTH-1:0]       mem_q [DEPTH];
    logic [AXI_WIDTH-1:0]       ram_rd_q;

    logic [NUM_RD-1:0]          rd_ack_q;
    logic [NUM_RD-1:0]          rd_ack_d;
    logic [NUM_RD-1:0]          rd_ack_out;
    logic                       wr_ack_q;
    logic                       wr_ack_d;
    logic [AXI_WIDTH-1:0]       hold_q [NUM_RD];
    logic [AXI_WIDTH-1:0]       hold_d [NUM_RD];

    logic                       unused_addr_bits;

    assign req[REQ_MM2S_0] = mm2s_0_rd_en;
    assign req[REQ_MM2S_1] = mm2s_1_rd_en;
    assign req[REQ_MM2S_2] = mm2s_2_rd_en;
    assign req[REQ_S2MM]   = s2mm_wr_en;

    assign rd_addr[REQ_MM2S_0] = mm2s_0_rd_addr;
    assign rd_addr[REQ_MM2S_1] = mm2s_1_rd_addr;
    assign rd_addr[REQ_MM2S_2] = mm2s_2_rd_addr;

`ifdef SA_RAM_RSP_STALL_EN
    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;

    assign lfsr_d = lfsr_next(lfsr_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign stall = (int'(lfsr_q) >= STALL_THRESH);
`else
    logic unused_stall_cfg;

    assign stall            = 1'b0;
    assign unused_stall_cfg = (STALL_THRESH > 255);
`endif

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req_i   (req),
        .stall_i (stall),
        .grant_o (grant),
        .ptr_o   (arb_ptr)
    );

    assign mm2s_0_rd_wait = mm2s_0_rd_en && !grant[REQ_MM2S_0];
    assign mm2s_1_rd_wait = mm2s_1_rd_en && !grant[REQ_MM2S_1];
    assign mm2s_2_rd_wait = mm2s_2_rd_en && !grant[REQ_MM2S_2];
    assign s2mm_wr_wait   = s2mm_wr_en   && !grant[REQ_S2MM];

    // Single shared RAM address: the winner's word index; byte offset and high bits drop out.
    always_comb begin
        acc_word = s2mm_wr_addr[LSB +: AW];
        for (int k = 0; k < NUM_RD; k++) begin
            if (grant[k]) begin
                acc_word = rd_addr[k][LSB +: AW];
            end
        end
    end

    assign rd_any = |grant[NUM_RD-1:0];
    assign mem_we = grant[REQ_S2MM] && !rst;

    assign unused_addr_bits = ^{mm2s_0_rd_addr, mm2s_1_rd_addr, mm2s_2_rd_addr, s2mm_wr_addr};

    // NOTE: the RAM array and its output register carry no reset so they map onto block RAM.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < AXI_STRB_WIDTH; b++) begin
                if (s2mm_wr_strb[b]) begin
                    mem_q[acc_word][b*8 +: 8] <= s2mm_wr_data[b*8 +: 8];
                end
            end
        end
        if (rd_any) begin
            ram_rd_q <= mem_q[acc_word];
        end
    end

    always_comb begin
        rd_ack_d = grant[NUM_RD-1:0];
        wr_ack_d = grant[REQ_S2MM];
        for (int k = 0; k < NUM_RD; k++) begin
            hold_d[k] = rd_ack_q[k] ? ram_rd_q : hold_q[k];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ack_q <= '0;
            wr_ack_q <= 1'b0;
            for (int k = 0; k < NUM_RD; k++) begin
                hold_q[k] <= '0;
            end
        end else begin
            rd_ack_q <= rd_ack_d;
            wr_ack_q <= wr_ack_d;
            for (int k = 0; k < NUM_RD; k++) begin
                hold_q[k] <= hold_d[k];
            end
        end
    end

    // Reset cancels an ack already in flight in the same cycle it is asserted.
    assign rd_ack_out = rd_ack_q & {NUM_RD{!rst}};

    assign mm2s_0_rd_ack  = rd_ack_out[REQ_MM2S_0];
    assign mm2s_1_rd_ack  = rd_ack_out[REQ_MM2S_1];
    assign mm2s_2_rd_ack  = rd_ack_out[REQ_MM2S_2];
    assign s2mm_wr_ack    = wr_ack_q && !rst;

    assign mm2s_0_rd_data = rd_ack_out[REQ_MM2S_0] ? ram_rd_q : hold_q[REQ_MM2S_0];
    assign mm2s_1_rd_data = rd_ack_out[REQ_MM2S_1] ? ram_rd_q : hold_q[REQ_MM2S_1];
    assign mm2s_2_rd_data = rd_ack_out[REQ_MM2S_2] ? ram_rd_q : hold_q[REQ_MM2S_2];

    a_ptr_reset: assert property (@(posedge clk) rst |=> (arb_ptr == '0));
    a_one_grant: assert property (@(posedge clk) $onehot0(grant));

endmodule

// File: tb/tb_sa_ram_responder.sv
// Directed bench for sa_ram_responder with a per-cycle reference model of arbitration and RAM.
module tb_sa_ram_responder;

    localparam logic [127:0] D1 = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
    localparam logic [127:0] P3 = 128'hFFFFFFFF_FFFFFFFF_00000000_FFFFFFFF;
    localparam logic [127:0] D4 = 128'h11112222_33334444_55556666_77778888;
    localparam logic [127:0] D5 = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   en;
    logic [31:0]  addr [4];
    logic [127:0] wdata;
    logic [15:0]  strb;
    logic [3:0]   wait_o;
    logic [3:0]   ack_o;
    logic [127:0] rdata [3];

    int vectors     = 0;
    int miscompares = 0;
    bit model_on    = 1'b0;

    // Reference model state: pointer, pending acks, visible read data, byte-granular memory.
    int           m_ptr;
    bit           m_ack   [4];
    logic [127:0] m_disp  [3];
    bit           m_known [3];
    logic [7:0]   m_mem   [int];

    logic [3:0]   exp_wait_tbl [4];

    always #5 clk = ~clk;

    sa_ram_responder dut (
        .clk            (clk),
        .rst            (rst),
        .mm2s_0_rd_en   (en[0]),
        .mm2s_0_rd_addr (addr[0]),
        .mm2s_0_rd_data (rdata[0]),
        .mm2s_0_rd_wait (wait_o[0]),
        .mm2s_0_rd_ack  (ack_o[0]),
        .mm2s_1_rd_en   (en[1]),
        .mm2s_1_rd_addr (addr[1]),
        .mm2s_1_rd_data (rdata[1]),
        .mm2s_1_rd_wait (wait_o[1]),
        .mm2s_1_rd_ack  (ack_o[1]),
        .mm2s_2_rd_en   (en[2]),
        .mm2s_2_rd_addr (addr[2]),
        .mm2s_2_rd_data (rdata[2]),
        .mm2s_2_rd_wait (wait_o[2]),
        .mm2s_2_rd_ack  (ack_o[2]),
        .s2mm_wr_en     (en[3]),
        .s2mm_wr_addr   (addr[3]),
        .s2mm_wr_data   (wdata),
        .s2mm_wr_strb   (strb),
        .s2mm_wr_wait   (wait_o[3]),
        .s2mm_wr_ack    (ack_o[3])
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    function automatic int word_of(input logic [31:0] a);
        return int'(a >> 4) % 4096;
    endfunction

    // Compare process: checks outputs against the model mid-cycle, then advances the model
    // to what the coming clock edge must produce.
    always @(negedge clk) begin
        int           g;
        int           w;
        bit           known;
        logic [127:0] d;
        if (model_on) begin
            g = -1;
            for (int i = 0; i < 4; i++) begin
                if (g < 0 && en[(m_ptr + i) % 4]) g = (m_ptr + i) % 4;
            end
            for (int k = 0; k < 4; k++) begin
                check($sformatf("model_wait%0d", k), 128'(wait_o[k]), 128'(en[k] && (g != k)));
                check($sformatf("model_ack%0d", k), 128'(ack_o[k]), 128'(m_ack[k] && !rst));
            end
            for (int k = 0; k < 3; k++) begin
                if (!rst && m_known[k]) check($sformatf("model_rdata%0d", k), rdata[k], m_disp[k]);
            end

            for (int k = 0; k < 4; k++) m_ack[k] = 1'b0;
            if (rst) begin
                m_ptr = 0;
                for (int k = 0; k < 3; k++) begin
                    m_disp[k]  = '0;
                    m_known[k] = 1'b1;
                end
            end else if (g >= 0) begin
                m_ack[g] = 1'b1;
                m_ptr    = (g + 1) % 4;
                w        = word_of(addr[g]);
                if (g == 3) begin
                    for (int b = 0; b < 16; b++) begin
                        if (strb[b]) m_mem[w*16 + b] = wdata[b*8 +: 8];
                    end
                end else begin
                    known = 1'b1;
                    d     = '0;
                    for (int b = 0; b < 16; b++) begin
                        if (m_mem.exists(w*16 + b)) d[b*8 +: 8] = m_mem[w*16 + b];
                        else known = 1'b0;
                    end
                    m_disp[g]  = d;
                    m_known[g] = known;
                end
            end
        end
    end

    initial begin
        exp_wait_tbl[0] = 4'b1110;
        exp_wait_tbl[1] = 4'b1101;
        exp_wait_tbl[2] = 4'b1011;
        exp_wait_tbl[3] = 4'b0111;
        m_ptr = 0;
        for (int k = 0; k < 4; k++) m_ack[k] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            m_disp[k]  = '0;
            m_known[k] = 1'b0;
        end

        // Reset and idle
        rst   = 1'b1;
        en    = '0;
        for (int k = 0; k < 4; k++) addr[k] = '0;
        wdata = '0;
        strb  = '0;
        step();
        model_on = 1'b1;
        sample();
        check("rst_ack", 128'(ack_o), 128'(4'b0000));
        check("rst_wait", 128'(wait_o), 128'(4'b0000));
        check("rst_rdata0", rdata[0], '0);
        check("rst_ptr", 128'(dut.u_arb.ptr_q), 128'(0));
        step();
        rst = 1'b0;

        // Single full write, then read of the same word
        en[3] = 1'b1; addr[3] = 32'h40; wdata = D1; strb = 16'hFFFF;
        sample();
        check("wr_wait_granted", 128'(wait_o[3]), 128'(0));
        step();
        en[3] = 1'b0; en[0] = 1'b1; addr[0] = 32'h40;
        sample();
        check("wr_ack", 128'(ack_o[3]), 128'(1));
        check("rd0_wait", 128'(wait_o[0]), 128'(0));
        step();
        en[0] = 1'b0;
        sample();
        check("rd0_ack", 128'(ack_o[0]), 128'(1));
        check("rd0_data", rdata[0], D1);
        step();
        sample();
        check("rd0_ack_drop", 128'(ack_o[0]), 128'(0));
        check("rd0_data_hold", rdata[0], D1);
        step();

        // Partial strobe: fill with FF, clear bytes 4..7, read back
        en[3] = 1'b1; addr[3] = 32'h40; wdata = '1; strb = 16'hFFFF;
        step();
        wdata = '0; strb = 16'h00F0;
        step();
        en[3] = 1'b0; en[1] = 1'b1; addr[1] = 32'h40;
        step();
        en[1] = 1'b0;
        sample();
        check("strb_data", rdata[1], P3);
        step();

        // Single continuous requester is granted every cycle
        en[0] = 1'b1; addr[0] = 32'h4F;
        for (int c = 0; c < 4; c++) begin
            sample();
            check($sformatf("stream_wait_c%0d", c), 128'(wait_o[0]), 128'(0));
            if (c > 0) check($sformatf("stream_data_c%0d", c), rdata[0], P3);
            step();
        end
        en[0] = 1'b0;
        step();

        // Arbitration: pointer back to 0, then all four requesting continuously
        rst = 1'b1;
        step();
        rst = 1'b0;
        en = 4'hF;
        addr[0] = 32'h40; addr[1] = 32'h40; addr[2] = 32'h40; addr[3] = 32'h80;
        wdata = D4; strb = 16'hFFFF;
        for (int c = 0; c < 8; c++) begin
            sample();
            check($sformatf("rr_wait_c%0d", c), 128'(wait_o), 128'(exp_wait_tbl[c % 4]));
            if (c > 0) check($sformatf("rr_ack_c%0d", c), 128'(ack_o), 128'(4'b0001 << ((c - 1) % 4)));
            step();
        end
        en = '0;
        step();

        // Wrap and alignment: word 1 reached via 0x10 and 0x1001F
        en[3] = 1'b1; addr[3] = 32'h10; wdata = D5; strb = 16'hFFFF;
        step();
        en[3] = 1'b0; en[2] = 1'b1; addr[2] = 32'h0001_001F;
        sample();
        check("wrap_wr_ack", 128'(ack_o[3]), 128'(1));
        step();
        en[2] = 1'b0;
        sample();
        check("wrap_rd_ack", 128'(ack_o[2]), 128'(1));
        check("wrap_rd_data", rdata[2], D5);
        step();

        // Reset mid-operation: cancelled read ack, write in reset cycle dropped
        en[1] = 1'b1; addr[1] = 32'h40;
        sample();
        check("midrst_rd_wait", 128'(wait_o[1]), 128'(0));
        step();
        rst = 1'b1; en[1] = 1'b0;
        en[3] = 1'b1; addr[3] = 32'h40; wdata = '0; strb = 16'hFFFF;
        sample();
        check("midrst_ack_cancel", 128'(ack_o[1]), 128'(0));
        step();
        rst = 1'b0; en[3] = 1'b0;
        sample();
        check("midrst_wr_ack", 128'(ack_o[3]), 128'(0));
        check("midrst_rdata1", rdata[1], '0);
        step();
        en[0] = 1'b1; addr[0] = 32'h40;
        step();
        en[0] = 1'b0;
        sample();
        check("midrst_wr_dropped", rdata[0], P3);
        step();
        step();

        model_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
